seq_detect_param: RTL

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_detect_param_if.sv | 28 ++
 rtl/seq_detect_param.sv | 88 ++++++++
 2 files changed

// File: rtl/seq_detect_param_if.sv
// Bus bundle for seq_detect_param.
//   master : drives x, x_valid, load, pat_in, ovl, clr_cnt; observes z, hit_cnt, fill
//   slave  : the detector side of the same signals
// PAT_W / CNT_W must match the parameters of the attached detector.
interface seq_detect_param_if #(
    parameter int PAT_W = 6,
    parameter int CNT_W = 8
);
    logic                           x;
    logic                           x_valid;
    logic                           load;
    logic [PAT_W-1:0]               pat_in;
    logic                           ovl;
    logic                           clr_cnt;
    logic                           z;
    logic [CNT_W-1:0]               hit_cnt;
    logic [$clog2(PAT_W+1)-1:0]     fill;

    modport master (
        output x, x_valid, load, pat_in, ovl, clr_cnt,
        input  z, hit_cnt, fill
    );

    modport slave (
        input  x, x_valid, load, pat_in, ovl, clr_cnt,
        output z, hit_cnt, fill
    );
endinterface

// File: rtl/seq_detect_param.sv
// Programmable serial pattern detector.
// Shifts qualified bits into a PAT_W-deep history and flags a match when the
// last PAT_W accepted bits equal the loaded pattern (MSB = oldest bit).
// Overlapping or non-overlapping detection is selected per cycle by ovl.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous reset, active low
//   bus      : seq_detect_param_if.slave
//              x/x_valid  serial data and qualifier
//              load/pat_in new pattern strobe and value
//              ovl        1 = overlapping, 0 = non-overlapping
//              clr_cnt    synchronous clear of hit_cnt
//              z          registered Moore detect flag (state HIT)
//              hit_cnt    saturating detection count
//              fill       valid history bits, saturating at PAT_W
module seq_detect_param #(
    parameter int               PAT_W   = 6,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(6'b110110),
    parameter int               CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    seq_detect_param_if.slave  bus
);
    localparam int               FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_THR = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic {HUNT, HIT} state_t;

    state_t             state;
    logic [PAT_W-1:0]   pat_reg;
    logic [PAT_W-1:0]   hist;
    logic [FILL_W-1:0]  fill;
    logic [CNT_W-1:0]   hit_cnt;

    logic               accept;
    logic [PAT_W-1:0]   shifted;
    logic               match;

    // load wins over x_valid, so a load cycle never counts as an accepted bit
    always_comb begin
        accept  = bus.x_valid & ~bus.load;
        shifted = {hist[PAT_W-2:0], bus.x};
        match   = accept && (shifted == pat_reg) && (fill >= FILL_THR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= HUNT;
            pat_reg <= DEF_PAT;
            hist    <= '0;
            fill    <= '0;
            hit_cnt <= '0;
        end else begin
            // HIT lasts only while consecutive cycles keep matching
            state <= match ? HIT : HUNT;

            // clear together with a match restarts at 1 so the hit is kept
            if (match) begin
                if (bus.clr_cnt)
                    hit_cnt <= CNT_W'(1);
                else if (hit_cnt != CNT_MAX)
                    hit_cnt <= hit_cnt + CNT_W'(1);
            end else if (bus.clr_cnt) begin
                hit_cnt <= '0;
            end

            if (bus.load) begin
                pat_reg <= bus.pat_in;
                hist    <= '0;
                fill    <= '0;
            end else if (accept) begin
                hist <= shifted;
                // non-overlap: history keeps shifting but must refill fully
                if (match && !bus.ovl)
                    fill <= '0;
                else if (fill != FILL_MAX)
                    fill <= fill + FILL_W'(1);
            end
        end
    end

    assign bus.z       = (state == HIT);
    assign bus.hit_cnt = hit_cnt;
    assign bus.fill    = fill;
endmodule
